// File: rtl/bitvault_pkg.sv
// Shared definitions for the BitVault access controller and register file.
//   DATA_W / ADDR_W : default register width and address width
//   op_e            : command opcodes carried on cmd_op
//   state_e         : controller sequencing states
package bitvault_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_XOR   = 2'b10,
    OP_INC   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/bitvault_access_ctrl_if.sv
// Command / response handshake bundle between a command producer and the
// BitVault access controller.
//   cmd_valid/cmd_ready : command handshake (producer -> controller)
//   cmd_op/addr/data    : command payload
//   rsp_valid/rsp_ready : response handshake (controller -> consumer)
//   rsp_data            : register value before the operation
// master: producer/consumer side.  slave: controller side.
interface bitvault_access_ctrl_if #(
  parameter int DATA_W = bitvault_pkg::DATA_W,
  parameter int ADDR_W = bitvault_pkg::ADDR_W
) ();
  import bitvault_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/bitvault_regfile.sv
// BitVault 2^ADDR_W x DATA_W register file: synchronous write, asynchronous
// read, no reset (contents survive controller reset).
//   clk      : write clock
//   we       : write enable, data_in stored at addr on rising edge
//   addr     : shared read/write address
//   data_in  : write data
//   data_out : combinational read of the addressed register
module bitvault_regfile #(
  parameter int DATA_W = bitvault_pkg::DATA_W,
  parameter int ADDR_W = bitvault_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  import bitvault_pkg::*;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/bitvault_access_ctrl.sv
// Command sequencer in front of the BitVault register file; the only driver
// of the file's pins. Runs WRITE, READ, XOR-RMW and INC-RMW one at a time.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : command / response handshake (slave side)
//   busy       : high whenever the sequencer is not IDLE
//   rf_we      : register-file write enable (one-cycle pulse in WB)
//   rf_addr    : register-file address, 0 while IDLE
//   rf_wdata   : register-file write data
//   rf_rdata   : register-file asynchronous read data
module bitvault_access_ctrl #(
  parameter int DATA_W = bitvault_pkg::DATA_W,
  parameter int ADDR_W = bitvault_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitvault_access_ctrl_if.slave bus,
  output logic                  busy,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_addr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [DATA_W-1:0]     rf_rdata
);
  import bitvault_pkg::*;

  state_e            state, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_d;

  // New value for a read-modify-write; INC wraps silently at 2^DATA_W.
  function automatic logic [DATA_W-1:0] rmw_result(input op_e op,
                                                   input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = old;
    case (op)
      OP_XOR:  res = old ^ mask;
      OP_INC:  res = old + DATA_W'(1);
      default: res = old;
    endcase
    return res;
  endfunction

  // Next-state and next-output decode. The rf_* pins are registered from the
  // upcoming state so the file sees stable address/data for a whole cycle.
  always_comb begin
    state_d    = state;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = '0;
    rf_wdata_d = rf_wdata;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = op_e'(bus.cmd_op);
          addr_d    = bus.cmd_addr;
          data_d    = bus.cmd_data;
          rf_addr_d = bus.cmd_addr;
          if (op_e'(bus.cmd_op) == OP_WRITE) begin
            state_d    = ST_WB;
            rf_we_d    = 1'b1;
            rf_wdata_d = bus.cmd_data;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // rf_addr already points at the target, so rf_rdata is the old value.
        rsp_data_d = rf_rdata;
        if (op_q == OP_READ) begin
          state_d = ST_RESP;
        end else begin
          state_d    = ST_WB;
          rf_we_d    = 1'b1;
          rf_addr_d  = addr_q;
          rf_wdata_d = rmw_result(op_q, rf_rdata, data_q);
        end
      end
      ST_WB: begin
        state_d = (op_q == OP_WRITE) ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_WRITE;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rf_we      <= rf_we_d;
      rf_addr    <= rf_addr_d;
      rf_wdata   <= rf_wdata_d;
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_bitvault_access_ctrl.sv
// Directed bench: BitVault access controller driving the BitVault register file.
module tb_bitvault_access_ctrl;
  import bitvault_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       rf_we;
  logic [1:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitvault_access_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bvif ();

  bitvault_access_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bvif),
    .busy     (busy),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata)
  );

  bitvault_regfile #(.DATA_W(8), .ADDR_W(2)) u_rf (
    .clk      (clk),
    .we       (rf_we),
    .addr     (rf_addr),
    .data_in  (rf_wdata),
    .data_out (rf_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, let one edge accept it.
  task automatic issue(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data);
    int waited;
    waited         = 0;
    bvif.cmd_valid = 1'b1;
    bvif.cmd_op    = op;
    bvif.cmd_addr  = addr;
    bvif.cmd_data  = data;
    while (!bvif.cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("accept_ready", 32'(bvif.cmd_ready), 32'd1);
    tick();
    bvif.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
    issue(2'b00, addr, data);
    check("wr_we",      32'(rf_we), 32'd1);
    check("wr_addr",    32'(rf_addr), 32'(addr));
    check("wr_wdata",   32'(rf_wdata), 32'(data));
    check("wr_busy",    32'(busy), 32'd1);
    tick();
    check("wr_we_off",  32'(rf_we), 32'd0);
    check("wr_ready",   32'(bvif.cmd_ready), 32'd1);
    check("wr_norsp",   32'(bvif.rsp_valid), 32'd0);
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [7:0] exp);
    issue(2'b01, addr, 8'h00);
    check("rd_exec_vld", 32'(bvif.rsp_valid), 32'd0);
    check("rd_exec_we",  32'(rf_we), 32'd0);
    check("rd_addr",     32'(rf_addr), 32'(addr));
    tick();
    check("rd_vld",      32'(bvif.rsp_valid), 32'd1);
    check("rd_data",     32'(bvif.rsp_data), 32'(exp));
    tick();
    check("rd_done",     32'(bvif.cmd_ready), 32'd1);
    check("rd_vld_off",  32'(bvif.rsp_valid), 32'd0);
  endtask

  task automatic do_rmw(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] mask,
                        input logic [7:0] old_v, input logic [7:0] new_v);
    issue(op, addr, mask);
    check("rmw_exec_we", 32'(rf_we), 32'd0);
    tick();
    check("rmw_wb_we",   32'(rf_we), 32'd1);
    check("rmw_wb_addr", 32'(rf_addr), 32'(addr));
    check("rmw_wb_data", 32'(rf_wdata), 32'(new_v));
    check("rmw_wb_vld",  32'(bvif.rsp_valid), 32'd0);
    tick();
    check("rmw_vld",     32'(bvif.rsp_valid), 32'd1);
    check("rmw_old",     32'(bvif.rsp_data), 32'(old_v));
    check("rmw_we_off",  32'(rf_we), 32'd0);
    tick();
    check("rmw_done",    32'(bvif.cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bvif.cmd_valid = 1'b0;
    bvif.cmd_op    = 2'b00;
    bvif.cmd_addr  = 2'd0;
    bvif.cmd_data  = 8'h00;
    bvif.rsp_ready = 1'b1;

    // 1: reset state
    tick();
    tick();
    check("rst_ready",  32'(bvif.cmd_ready), 32'd1);
    check("rst_vld",    32'(bvif.rsp_valid), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_we",     32'(rf_we), 32'd0);
    check("rst_addr",   32'(rf_addr), 32'd0);
    check("rst_wdata",  32'(rf_wdata), 32'd0);
    check("rst_rdata",  32'(bvif.rsp_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // 2: WRITE then READ same register
    do_write(2'd2, 8'hA5);
    do_read(2'd2, 8'hA5);

    // 3: INC wrap
    do_write(2'd1, 8'hFF);
    do_rmw(2'b11, 2'd1, 8'h00, 8'hFF, 8'h00);
    do_read(2'd1, 8'h00);

    // 4: XOR
    do_write(2'd3, 8'h0F);
    do_rmw(2'b10, 2'd3, 8'hF0, 8'h0F, 8'hFF);
    do_read(2'd3, 8'hFF);

    // 5: response stall
    do_write(2'd0, 8'h3C);
    bvif.rsp_ready = 1'b0;
    issue(2'b01, 2'd0, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_vld",   32'(bvif.rsp_valid), 32'd1);
      check("stall_data",  32'(bvif.rsp_data), 32'h3C);
      check("stall_ready", 32'(bvif.cmd_ready), 32'd0);
      tick();
    end
    bvif.rsp_ready = 1'b1;
    check("stall_last",  32'(bvif.rsp_valid), 32'd1);
    tick();
    check("stall_rel_vld",   32'(bvif.rsp_valid), 32'd0);
    check("stall_rel_ready", 32'(bvif.cmd_ready), 32'd1);

    // 6: reset during EXEC of an INC
    do_write(2'd1, 8'h10);
    issue(2'b11, 2'd1, 8'h00);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_vld",   32'(bvif.rsp_valid), 32'd0);
    check("mid_rst_we",    32'(rf_we), 32'd0);
    check("mid_rst_addr",  32'(rf_addr), 32'd0);
    check("mid_rst_rdata", 32'(bvif.rsp_data), 32'd0);
    tick();
    check("mid_rst_ready", 32'(bvif.cmd_ready), 32'd1);
    check("mid_rst_vld2",  32'(bvif.rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    do_read(2'd1, 8'h10);
    do_write(2'd2, 8'h5A);
    do_read(2'd2, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
